// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch/decode sequencer. Fetches a word at pc_out,
//               decodes sequential / BZ / JMP / JR / HALT and commands the PC
//               block through pc_ctl, imm, sr1_val and a pc_latch_data strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int PC_BITS = 6
) (
  input  logic               clka,
  input  logic               reset,
  input  logic [PC_BITS-1:0] pc_out,
  output logic               mem_req,
  output logic [PC_BITS-1:0] mem_addr,
  input  logic [7:0]         mem_rdata,
  input  logic               mem_ack,
  input  logic               zero_flag,
  output logic [1:0]         rf_raddr,
  input  logic [7:0]         rf_rdata,
  input  logic               stall,
  output logic               pc_latch_data,
  output logic [1:0]         pc_ctl,
  output logic [PC_BITS-1:0] imm,
  output logic [7:0]         sr1_val,
  output logic [7:0]         instr_out,
  output logic               instr_valid,
  output logic               halted
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_REGRD  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] c_PC_INC  = 2'b00;
  localparam logic [1:0] c_PC_REL  = 2'b01;
  localparam logic [1:0] c_PC_IMM  = 2'b10;
  localparam logic [1:0] c_PC_REG  = 2'b11;

  state_t             r_state;
  logic [PC_BITS-1:0] w_field;

  // 6-bit offset/target field of the held instruction, sized to the PC
  assign w_field  = PC_BITS'(instr_out[5:0]);

  // The address is only qualified by mem_req, so it simply tracks the PC
  assign mem_addr = pc_out;

  // The strobe must drop in the same cycle stall rises, so it is decoded
  // from the registered state and the live stall input
  assign pc_latch_data = (r_state == ST_UPDATE) && !stall;

  // Main sequencer: state plus all registered outputs
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_FETCH;
      mem_req     <= 1'b0;
      rf_raddr    <= 2'b00;
      pc_ctl      <= c_PC_INC;
      imm         <= '0;
      sr1_val     <= 8'h00;
      instr_out   <= 8'h00;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          // Out of reset the request is raised on the first edge; an ack is
          // only honoured once the request is actually visible
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            mem_req     <= 1'b0;
            instr_out   <= mem_rdata;
            instr_valid <= (mem_rdata[7:6] == 2'b00);
            r_state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (instr_out[7:6])
            2'b00: begin
              pc_ctl  <= c_PC_INC;
              r_state <= ST_UPDATE;
            end
            2'b01: begin
              // zero_flag is sampled here only; later changes are ignored
              if (zero_flag) begin
                pc_ctl <= c_PC_REL;
                imm    <= w_field;
              end else begin
                pc_ctl <= c_PC_INC;
              end
              r_state <= ST_UPDATE;
            end
            2'b10: begin
              pc_ctl  <= c_PC_IMM;
              imm     <= w_field;
              r_state <= ST_UPDATE;
            end
            default: begin
              if (instr_out[3:0] == 4'hF) begin
                halted  <= 1'b1;
                r_state <= ST_HALT;
              end else begin
                rf_raddr <= instr_out[5:4];
                r_state  <= ST_REGRD;
              end
            end
          endcase
        end
        ST_REGRD: begin
          sr1_val <= rf_rdata;
          pc_ctl  <= c_PC_REG;
          r_state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          if (!stall) begin
            mem_req <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          mem_req <= 1'b0;
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed testbench for fetch_sequencer. Inputs are driven and
//               outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int PC_BITS = 6;

  logic               clka;
  logic               reset;
  logic [PC_BITS-1:0] pc_out;
  logic               mem_req;
  logic [PC_BITS-1:0] mem_addr;
  logic [7:0]         mem_rdata;
  logic               mem_ack;
  logic               zero_flag;
  logic [1:0]         rf_raddr;
  logic [7:0]         rf_rdata;
  logic               stall;
  logic               pc_latch_data;
  logic [1:0]         pc_ctl;
  logic [PC_BITS-1:0] imm;
  logic [7:0]         sr1_val;
  logic [7:0]         instr_out;
  logic               instr_valid;
  logic               halted;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_sequencer #(.PC_BITS(PC_BITS)) dut (
    .clka          (clka),
    .reset         (reset),
    .pc_out        (pc_out),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .zero_flag     (zero_flag),
    .rf_raddr      (rf_raddr),
    .rf_rdata      (rf_rdata),
    .stall         (stall),
    .pc_latch_data (pc_latch_data),
    .pc_ctl        (pc_ctl),
    .imm           (imm),
    .sr1_val       (sr1_val),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .halted        (halted)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Reset values, then release: first edge after release raises mem_req
  task automatic test_reset();
    reset = 1'b0; pc_out = 6'h10; mem_rdata = 8'h00; mem_ack = 1'b0;
    zero_flag = 1'b0; rf_rdata = 8'h00; stall = 1'b0;
    repeat (2) @(negedge clka);
    tests_run++; if (mem_req !== 1'b0)       begin tests_failed++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    tests_run++; if (pc_latch_data !== 1'b0) begin tests_failed++; $display("FAIL rst_latch: got %b expected 0", pc_latch_data); end
    tests_run++; if (pc_ctl !== 2'b00)       begin tests_failed++; $display("FAIL rst_pc_ctl: got %b expected 00", pc_ctl); end
    tests_run++; if (imm !== 6'h00)          begin tests_failed++; $display("FAIL rst_imm: got %h expected 00", imm); end
    tests_run++; if (sr1_val !== 8'h00)      begin tests_failed++; $display("FAIL rst_sr1_val: got %h expected 00", sr1_val); end
    tests_run++; if (instr_out !== 8'h00)    begin tests_failed++; $display("FAIL rst_instr_out: got %h expected 00", instr_out); end
    tests_run++; if (instr_valid !== 1'b0)   begin tests_failed++; $display("FAIL rst_instr_valid: got %b expected 0", instr_valid); end
    tests_run++; if (halted !== 1'b0)        begin tests_failed++; $display("FAIL rst_halted: got %b expected 0", halted); end
    tests_run++; if (rf_raddr !== 2'b00)     begin tests_failed++; $display("FAIL rst_rf_raddr: got %b expected 00", rf_raddr); end
    reset = 1'b1;
    @(negedge clka);
    tests_run++; if (mem_req !== 1'b1)       begin tests_failed++; $display("FAIL rel_mem_req: got %b expected 1", mem_req); end
    tests_run++; if (mem_addr !== 6'h10)     begin tests_failed++; $display("FAIL rel_mem_addr: got %h expected 10", mem_addr); end
  endtask

  // Sequential 8'h05 with immediate ack
  task automatic test_sequential();
    mem_rdata = 8'h05; mem_ack = 1'b1;
    @(negedge clka);
    mem_ack = 1'b0; mem_rdata = 8'h00;
    tests_run++; if (instr_valid !== 1'b1)   begin tests_failed++; $display("FAIL seq_valid: got %b expected 1", instr_valid); end
    tests_run++; if (instr_out !== 8'h05)    begin tests_failed++; $display("FAIL seq_instr: got %h expected 05", instr_out); end
    tests_run++; if (mem_req !== 1'b0)       begin tests_failed++; $display("FAIL seq_req_low: got %b expected 0", mem_req); end
    tests_run++; if (pc_latch_data !== 1'b0) begin tests_failed++; $display("FAIL seq_no_early_latch: got %b expected 0", pc_latch_data); end
    @(negedge clka);
    tests_run++; if (pc_latch_data !== 1'b1) begin tests_failed++; $display("FAIL seq_latch: got %b expected 1", pc_latch_data); end
    tests_run++; if (pc_ctl !== 2'b00)       begin tests_failed++; $display("FAIL seq_pc_ctl: got %b expected 00", pc_ctl); end
    tests_run++; if (instr_valid !== 1'b0)   begin tests_failed++; $display("FAIL seq_valid_pulse: got %b expected 0", instr_valid); end
    pc_out = 6'h11;
    @(negedge clka);
    tests_run++; if (pc_latch_data !== 1'b0) begin tests_failed++; $display("FAIL seq_latch_once: got %b expected 0", pc_latch_data); end
    tests_run++; if (mem_req !== 1'b1)       begin tests_failed++; $display("FAIL seq_refetch: got %b expected 1", mem_req); end
    tests_run++; if (mem_addr !== 6'h11)     begin tests_failed++; $display("FAIL seq_next_addr: got %h expected 11", mem_addr); end
  endtask

  // BZ 8'h44 taken then not taken
  task automatic test_bz();
    zero_flag = 1'b1; mem_rdata = 8'h44; mem_ack = 1'b1;
    @(negedge clka);
    mem_ack = 1'b0;
    tests_run++; if (instr_valid !== 1'b0)   begin tests_failed++; $display("FAIL bzt_valid: got %b expected 0", instr_valid); end
    @(negedge clka);
    zero_flag = 1'b0;
    tests_run++; if (pc_ctl !== 2'b01)       begin tests_failed++; $display("FAIL bzt_pc_ctl: got %b expected 01", pc_ctl); end
    tests_run++; if (imm !== 6'h04)          begin tests_failed++; $display("FAIL bzt_imm: got %h expected 04", imm); end
    tests_run++; if (pc_latch_data !== 1'b1) begin tests_failed++; $display("FAIL bzt_latch: got %b expected 1", pc_latch_data); end
    pc_out = 6'h15;
    @(negedge clka);
    tests_run++; if (mem_req !== 1'b1)       begin tests_failed++; $display("FAIL bzt_refetch: got %b expected 1", mem_req); end
    mem_rdata = 8'h44; mem_ack = 1'b1;
    @(negedge clka);
    mem_ack = 1'b0;
    tests_run++; if (instr_valid !== 1'b0)   begin tests_failed++; $display("FAIL bzn_valid: got %b expected 0", instr_valid); end
    @(negedge clka);
    zero_flag = 1'b1;
    tests_run++; if (pc_ctl !== 2'b00)       begin tests_failed++; $display("FAIL bzn_pc_ctl: got %b expected 00", pc_ctl); end
    tests_run++; if (pc_latch_data !== 1'b1) begin tests_failed++; $display("FAIL bzn_latch: got %b expected 1", pc_latch_data); end
    pc_out = 6'h16;
    @(negedge clka);
    zero_flag = 1'b0;
    tests_run++; if (mem_req !== 1'b1)       begin tests_failed++; $display("FAIL bzn_refetch: got %b expected 1", mem_req); end
  endtask

  // JR 8'hE0 with register value 8'h2A, valid only in the REGRD cycle
  task automatic test_jr();
    mem_rdata = 8'hE0; mem_ack = 1'b1;
    @(negedge clka);
    mem_ack = 1'b0; rf_rdata = 8'hFF;
    tests_run++; if (instr_valid !== 1'b0)   begin tests_failed++; $display("FAIL jr_valid: got %b expected 0", instr_valid); end
    @(negedge clka);
    tests_run++; if (rf_raddr !== 2'd2)      begin tests_failed++; $display("FAIL jr_raddr: got %0d expected 2", rf_raddr); end
    tests_run++; if (pc_latch_data !== 1'b0) begin tests_failed++; $display("FAIL jr_no_latch_regrd: got %b expected 0", pc_latch_data); end
    tests_run++; if (mem_req !== 1'b0)       begin tests_failed++; $display("FAIL jr_req_low: got %b expected 0", mem_req); end
    rf_rdata = 8'h2A;
    @(negedge clka);
    rf_rdata = 8'h00;
    tests_run++; if (sr1_val !== 8'h2A)      begin tests_failed++; $display("FAIL jr_sr1_val: got %h expected 2a", sr1_val); end
    tests_run++; if (pc_ctl !== 2'b11)       begin tests_failed++; $display("FAIL jr_pc_ctl: got %b expected 11", pc_ctl); end
    tests_run++; if (pc_latch_data !== 1'b1) begin tests_failed++; $display("FAIL jr_latch: got %b expected 1", pc_latch_data); end
    pc_out = 6'h2A;
    @(negedge clka);
    tests_run++; if (mem_req !== 1'b1)       begin tests_failed++; $display("FAIL jr_refetch: got %b expected 1", mem_req); end
    tests_run++; if (mem_addr !== 6'h2A)     begin tests_failed++; $display("FAIL jr_addr: got %h expected 2a", mem_addr); end
  endtask

  // JMP 8'hBF with a 3-cycle ack delay and 4 stalled UPDATE cycles
  task automatic test_stall_wait();
    int pulses;
    pulses = 0;
    pc_out = 6'h22; mem_rdata = 8'hBF; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (mem_req !== 1'b1 || mem_addr !== 6'h22) begin tests_failed++; $display("FAIL wait_req_%0d: got req=%b addr=%h expected req=1 addr=22", i, mem_req, mem_addr); end
      @(negedge clka);
    end
    mem_ack = 1'b1;
    @(negedge clka);
    mem_ack = 1'b0; stall = 1'b1;
    tests_run++; if (instr_out !== 8'hBF)    begin tests_failed++; $display("FAIL jmp_instr: got %h expected bf", instr_out); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clka);
      if (pc_latch_data === 1'b1) pulses++;
      tests_run++; if (pc_ctl !== 2'b10 || imm !== 6'h3F) begin tests_failed++; $display("FAIL stall_hold_%0d: got ctl=%b imm=%h expected ctl=10 imm=3f", i, pc_ctl, imm); end
      tests_run++; if (mem_req !== 1'b0 || mem_addr !== 6'h22) begin tests_failed++; $display("FAIL stall_req_%0d: got req=%b addr=%h expected req=0 addr=22", i, mem_req, mem_addr); end
    end
    tests_run++; if (pulses !== 0)           begin tests_failed++; $display("FAIL stall_no_pulse: got %0d pulses expected 0", pulses); end
    stall = 1'b0;
    #1;
    tests_run++; if (pc_latch_data !== 1'b1) begin tests_failed++; $display("FAIL stall_release_latch: got %b expected 1", pc_latch_data); end
    tests_run++; if (pc_ctl !== 2'b10 || imm !== 6'h3F) begin tests_failed++; $display("FAIL stall_release_ctl: got ctl=%b imm=%h expected ctl=10 imm=3f", pc_ctl, imm); end
    pc_out = 6'h3F;
    @(negedge clka);
    tests_run++; if (pc_latch_data !== 1'b0 || mem_req !== 1'b1) begin tests_failed++; $display("FAIL stall_after: got latch=%b req=%b expected latch=0 req=1", pc_latch_data, mem_req); end
  endtask

  // Reset asserted while UPDATE is stalled (JMP 8'h85)
  task automatic test_reset_during_stall();
    int pulses;
    pulses = 0;
    mem_rdata = 8'h85; mem_ack = 1'b1;
    @(negedge clka);
    mem_ack = 1'b0; stall = 1'b1;
    @(negedge clka);
    tests_run++; if (pc_ctl !== 2'b10 || imm !== 6'h05) begin tests_failed++; $display("FAIL rsu_pre: got ctl=%b imm=%h expected ctl=10 imm=05", pc_ctl, imm); end
    reset = 1'b0;
    #1;
    tests_run++; if (pc_ctl !== 2'b00 || imm !== 6'h00) begin tests_failed++; $display("FAIL rsu_ctl: got ctl=%b imm=%h expected ctl=00 imm=00", pc_ctl, imm); end
    tests_run++; if (instr_out !== 8'h00 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL rsu_clear: got instr=%h req=%b expected instr=00 req=0", instr_out, mem_req); end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; if (pc_latch_data === 1'b1) pulses++;
      @(negedge clka);
    end
    tests_run++; if (pulses !== 0)           begin tests_failed++; $display("FAIL rsu_no_pulse: got %0d pulses expected 0", pulses); end
    reset = 1'b1; pc_out = 6'h05;
    @(negedge clka);
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== 6'h05) begin tests_failed++; $display("FAIL rsu_resume: got req=%b addr=%h expected req=1 addr=05", mem_req, mem_addr); end
  endtask

  // HALT 8'hCF absorbs activity until reset
  task automatic test_halt();
    int reqs;
    int pulses;
    reqs = 0; pulses = 0;
    mem_rdata = 8'hCF; mem_ack = 1'b1;
    @(negedge clka);
    mem_ack = 1'b0;
    tests_run++; if (instr_valid !== 1'b0)   begin tests_failed++; $display("FAIL halt_valid: got %b expected 0", instr_valid); end
    @(negedge clka);
    tests_run++; if (halted !== 1'b1)        begin tests_failed++; $display("FAIL halt_flag: got %b expected 1", halted); end
    mem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stall = i[0];
      #1;
      if (mem_req === 1'b1) reqs++;
      if (pc_latch_data === 1'b1) pulses++;
      @(negedge clka);
    end
    mem_ack = 1'b0; stall = 1'b0;
    tests_run++; if (reqs !== 0)             begin tests_failed++; $display("FAIL halt_no_req: got %0d expected 0", reqs); end
    tests_run++; if (pulses !== 0)           begin tests_failed++; $display("FAIL halt_no_pulse: got %0d expected 0", pulses); end
    tests_run++; if (halted !== 1'b1)        begin tests_failed++; $display("FAIL halt_sticky: got %b expected 1", halted); end
    reset = 1'b0;
    #1;
    tests_run++; if (halted !== 1'b0)        begin tests_failed++; $display("FAIL halt_rst: got %b expected 0", halted); end
    @(negedge clka);
    reset = 1'b1; pc_out = 6'h00;
    @(negedge clka);
    tests_run++; if (mem_req !== 1'b1 || halted !== 1'b0) begin tests_failed++; $display("FAIL halt_resume: got req=%b halted=%b expected req=1 halted=0", mem_req, halted); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_bz();
    test_jr();
    test_stall_wait();
    test_reset_during_stall();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: PC_BITS, 6, width of program counter, instruction address and imm.
REQ-002 clka  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-004 pc_out  input  PC_BITS  current program counter from the PC block.
REQ-005 mem_req  output  1  instruction-memory read request.
REQ-006 mem_addr  output  PC_BITS  instruction-memory read address.
REQ-007 mem_rdata  input  8  instruction word; sampled on the edge where mem_ack=1.
REQ-008 mem_ack  input  1  read-complete strobe from instruction memory.
REQ-009 zero_flag  input  1  ALU zero flag, used by conditional branch.
REQ-010 rf_raddr  output  2  register-file read address for jump-register.
REQ-011 rf_rdata  input  8  register-file read data, valid one cycle after rf_raddr.
REQ-012 stall  input  1  downstream hold request.
REQ-013 pc_latch_data  output  1  one-cycle strobe commanding the PC to update.
REQ-014 pc_ctl  output  2  PC update select: 00 PC+1, 01 PC+imm (mod 2^PC_BITS), 10 load imm, 11 load sr1_val[PC_BITS-1:0].
REQ-015 imm  output  PC_BITS  immediate for pc_ctl 01/10.
REQ-016 sr1_val  output  8  register value for pc_ctl 11.
REQ-017 instr_out  output  8  last fetched instruction.
REQ-018 instr_valid  output  1  one-cycle pulse: instr_out is a non-control instruction to execute.
REQ-019 halted  output  1  high while in HALT state.

Function
REQ-020 States: FETCH, DECODE, REGRD, UPDATE, HALT; reset state FETCH.
REQ-021 Decode on instr[7:6]: 00 sequential, 01 BZ (offset instr[5:0]), 10 JMP (target instr[5:0]), 11 JR (reg instr[5:4]); 11 with instr[3:0]=4'hF is HALT.
REQ-022 FETCH: mem_req=1, mem_addr=pc_out; stay until mem_ack=1, then capture mem_rdata into instr_out, go DECODE.
REQ-023 DECODE (one cycle): sequential -> instr_valid=1, pc_ctl=00; BZ with zero_flag=1 -> pc_ctl=01, imm=instr[5:0]; BZ with zero_flag=0 -> pc_ctl=00; JMP -> pc_ctl=10, imm=instr[5:0]; all go UPDATE; JR -> rf_raddr=instr[5:4], go REGRD; HALT -> go HALT.
REQ-024 REGRD (one cycle): capture rf_rdata into sr1_val, pc_ctl=11, go UPDATE.
REQ-025 UPDATE: if stall=0, pc_latch_data=1 for exactly this cycle, go FETCH; if stall=1, pc_latch_data=0, hold state and pc_ctl/imm/sr1_val stable.
REQ-026 zero_flag sampled only in DECODE; later changes ignored for that instruction.
REQ-027 pc_latch_data never asserted outside UPDATE; at most one pulse per fetched instruction.
REQ-028 mem_ack outside FETCH ignored; mem_req low in all states except FETCH.
REQ-029 HALT: absorbing; halted=1, mem_req=0, pc_latch_data=0; exit only via reset.
REQ-030 Fetch-to-next-fetch latency with zero-wait memory, no stall: 3 cycles (FETCH, DECODE, UPDATE); JR: 4 cycles.

Reset
REQ-031 reset=0 forces state FETCH, mem_req=0 while asserted, pc_latch_data=0, pc_ctl=00, imm=0, sr1_val=0, instr_out=0, instr_valid=0, halted=0, rf_raddr=0.
REQ-032 Reset asserted mid-operation (any state, including stalled UPDATE) aborts the instruction with no pc_latch_data pulse; first edge after release starts a FETCH of pc_out.

Verification
REQ-033 Sequential: mem_rdata=8'h05, ack immediate -> instr_valid pulse in DECODE, pc_latch_data pulse with pc_ctl=00 two cycles after ack edge.
REQ-034 BZ: 8'h44, zero_flag=1 -> pc_ctl=01, imm=6'h04; same with zero_flag=0 -> pc_ctl=00; no instr_valid either case.
REQ-035 JR: 8'hE0, rf_rdata=8'h2A -> rf_raddr=2, sr1_val=8'h2A, pc_ctl=11, pulse one cycle after REGRD.
REQ-036 Stall/wait: mem_ack delayed 3 cycles, then stall=1 for 4 cycles in UPDATE (JMP 8'hBF) -> mem_addr held, pc_ctl=10, imm=6'h3F held, single pulse after stall drops.
REQ-037 HALT 8'hCF -> halted=1, no further mem_req or pulses over 20 cycles; reset=0 then 1 -> FETCH resumes, halted=0.
REQ-038 Reset during stalled UPDATE -> no pc_latch_data pulse, all outputs at REQ-031 values.
